// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32IM sequencer.
// Build option: MC_CTRL_MULDIV_EN adds the multicycle divide state.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWrite,
        StMemWb,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJalr,
        StJal,
        StLui,
        StTrap
`ifdef MC_CTRL_MULDIV_EN
        , StDiv
`endif
    } mc_state_t;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Writeback / PC-next result select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // Request to alu_dec
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Immediate formats, same encoding as the single-cycle main_dec
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_controller_imm_dec.sv
// Combinational opcode -> immediate-format decode, independent of FSM state.
module mc_imm_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_src_o
);

    // Immediate format per opcode; formats without an immediate fall to I
    always_comb begin
        imm_src_o = IMM_I;
        case (opcode_i)
            OP_STORE:          imm_src_o = IMM_S;
            OP_BRANCH:         imm_src_o = IMM_B;
            OP_JAL:            imm_src_o = IMM_J;
            OP_LUI, OP_AUIPC:  imm_src_o = IMM_U;
            default:           imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore sequencer for the RV32IM core with a shared memory port.
// Build option: MC_CTRL_MULDIV_EN routes div/divu/rem/remu through a
// divider wait state.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7b0_i,
    input  logic                 taken_br_i,
    input  logic                 mem_ready_i,
    input  logic                 div_done_i,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic                 adr_src_o,
    output logic                 ir_write_o,
    output logic                 pc_write_o,
    output logic                 reg_write_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           result_src_o,
    output logic [2:0]           imm_src_o,
    output logic [1:0]           alu_op_o,
    output logic                 div_start_o,
    output logic                 illegal_instr_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    mc_state_t state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic illegal_q, illegal_d;

    logic mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write, div_start;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [2:0] imm_src;

    mc_imm_dec u_imm_dec (
        .opcode_i  (opcode_i),
        .imm_src_o (imm_src)
    );

`ifdef MC_CTRL_MULDIV_EN
    logic div_busy_q;
    logic is_div;
    logic unused_funct;
    assign is_div       = funct7b0_i & funct3_i[2];
    assign unused_funct = ^funct3_i[1:0];

    // Marks cycles after the first S_DIV cycle so the launch is a single pulse
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) div_busy_q <= 1'b0;
        else         div_busy_q <= (state_q == StDiv);
    end
`else
    logic unused_muldiv;
    assign unused_muldiv = ^{funct3_i, funct7b0_i, div_done_i};
`endif

    // State, retired-instruction counter and sticky trap flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StFetch;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and Moore decode of datapath controls
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        div_start  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready_i;
                pc_update  = mem_ready_i;
                if (mem_ready_i) state_d = StDecode;
            end
            StDecode: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_RTYPE:          state_d = StExecR;
                    OP_IALU:           state_d = StExecI;
                    OP_BRANCH:         state_d = StBranch;
                    OP_JAL:            state_d = StJal;
                    OP_JALR:           state_d = StJalr;
                    OP_LUI:            state_d = StLui;
                    OP_AUIPC:          state_d = StAluWb;
                    default:           state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode_i == OP_LOAD) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready_i) state_d = StMemWb;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready_i) state_d = StFetch;
            end
            StMemWb: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StExecR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
`ifdef MC_CTRL_MULDIV_EN
                state_d   = is_div ? StDiv : StAluWb;
`else
                state_d   = StAluWb;
`endif
            end
            StExecI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_BRANCH;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                state_d    = StFetch;
            end
            StJalr: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = StJal;
            end
            StJal: begin
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_d    = StAluWb;
            end
            StLui: begin
                result_src = RES_IMMEXT;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
`ifdef MC_CTRL_MULDIV_EN
            StDiv: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                div_start = ~div_busy_q;
                if (div_done_i) state_d = StAluWb;
            end
`endif
            default: state_d = StTrap;
        endcase
    end

    // Retire on every re-entry into fetch; flag latches on trap entry
    always_comb begin
        instret_d = instret_q;
        if ((state_q != StFetch) && (state_d == StFetch)) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
        illegal_d = illegal_q | (state_d == StTrap);
    end

    // Outputs are forced low while reset is held, dropping requests at once
    assign mem_req_o       = mem_req & ~reset_i;
    assign mem_write_o     = mem_write & ~reset_i;
    assign adr_src_o       = adr_src & ~reset_i;
    assign ir_write_o      = ir_write & ~reset_i;
    assign pc_write_o      = (pc_update | (branch & taken_br_i)) & ~reset_i;
    assign reg_write_o     = reg_write & ~reset_i;
    assign div_start_o     = div_start & ~reset_i;
    assign alu_src_a_o     = alu_src_a & {2{~reset_i}};
    assign alu_src_b_o     = alu_src_b & {2{~reset_i}};
    assign result_src_o    = result_src & {2{~reset_i}};
    assign alu_op_o        = alu_op & {2{~reset_i}};
    assign imm_src_o       = imm_src & {3{~reset_i}};
    assign illegal_instr_o = illegal_q & ~reset_i;
    assign instret_o       = instret_q & {CNT_WIDTH{~reset_i}};

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle pushes the expected
// control vector, which is popped and compared mid-cycle.
module tb_mc_controller;

    localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MW = 4, ST_MWB = 5,
                   ST_ER = 6, ST_EI = 7, ST_AW = 8, ST_BR = 9, ST_JR = 10, ST_J = 11,
                   ST_LUI = 12, ST_TR = 13, ST_DV = 14;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic        funct7b0_i, taken_br_i, mem_ready_i, div_done_i;
    logic        mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, result_src_o, alu_op_o;
    logic [2:0]  imm_src_o;
    logic        div_start_o, illegal_instr_o;
    logic [31:0] instret_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_instret = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] dut_vec;

    mc_controller #(.CNT_WIDTH(32)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .opcode_i        (opcode_i),
        .funct3_i        (funct3_i),
        .funct7b0_i      (funct7b0_i),
        .taken_br_i      (taken_br_i),
        .mem_ready_i     (mem_ready_i),
        .div_done_i      (div_done_i),
        .mem_req_o       (mem_req_o),
        .mem_write_o     (mem_write_o),
        .adr_src_o       (adr_src_o),
        .ir_write_o      (ir_write_o),
        .pc_write_o      (pc_write_o),
        .reg_write_o     (reg_write_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .result_src_o    (result_src_o),
        .imm_src_o       (imm_src_o),
        .alu_op_o        (alu_op_o),
        .div_start_o     (div_start_o),
        .illegal_instr_o (illegal_instr_o),
        .instret_o       (instret_o)
    );

    always #5 clk_i = ~clk_i;

    assign dut_vec = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                      alu_src_a_o, alu_src_b_o, result_src_o, alu_op_o, div_start_o,
                      illegal_instr_o};

    // Expected controls per state, written straight from the state table
    function automatic logic [15:0] exp_vec(int st, logic rdy, logic tk, logic first);
        logic mreq, mwr, adr, irw, pcw, rw, dst, ill;
        logic [1:0] a, b, res, op;
        {mreq, mwr, adr, irw, pcw, rw, dst, ill} = '0;
        {a, b, res, op} = '0;
        case (st)
            ST_F:   begin mreq = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            ST_D:   begin a = 2'b01; b = 2'b01; end
            ST_MA:  begin a = 2'b10; b = 2'b01; end
            ST_MR:  begin mreq = 1; adr = 1; end
            ST_MW:  begin mreq = 1; mwr = 1; adr = 1; end
            ST_MWB: begin res = 2'b01; rw = 1; end
            ST_ER:  begin a = 2'b10; op = 2'b10; end
            ST_EI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
            ST_AW:  begin rw = 1; end
            ST_BR:  begin a = 2'b10; op = 2'b01; pcw = tk; end
            ST_JR:  begin a = 2'b10; b = 2'b01; end
            ST_J:   begin pcw = 1; a = 2'b01; b = 2'b10; end
            ST_LUI: begin res = 2'b11; rw = 1; end
            ST_TR:  begin ill = 1; end
            ST_DV:  begin a = 2'b10; op = 2'b10; dst = first; end
            default: ;
        endcase
        return {mreq, mwr, adr, irw, pcw, rw, a, b, res, op, dst, ill};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: push expectation with the stimulus, pop at the falling edge
    task automatic cyc(string tag, int st, logic rdy, logic tk, logic first);
        mem_ready_i = rdy;
        taken_br_i  = tk;
        exp_q.push_back(exp_vec(st, rdy, tk, first));
        tag_q.push_back(tag);
        @(negedge clk_i);
        check(tag_q.pop_front(), {16'h0, dut_vec}, {16'h0, exp_q.pop_front()});
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ir(string tag, logic [6:0] op, logic [2:0] f3, logic f7, logic [2:0] imm);
        opcode_i   = op;
        funct3_i   = f3;
        funct7b0_i = f7;
        #1;
        check({tag, "_imm"}, {29'h0, imm_src_o}, {29'h0, imm});
    endtask

    task automatic fetch(int waits);
        check("instret", instret_o, exp_instret);
        for (int i = 0; i < waits; i++) cyc("fetch_wait", ST_F, 1'b0, 1'b0, 1'b0);
        cyc("fetch", ST_F, 1'b1, 1'b0, 1'b0);
        cyc("decode", ST_D, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        {opcode_i, funct3_i, funct7b0_i, taken_br_i, mem_ready_i, div_done_i} = '0;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_outs", {16'h0, dut_vec}, 32'h0);
        check("rst_instret", instret_o, 32'h0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // add x3,x1,x2
        set_ir("add", 7'b0110011, 3'b000, 1'b0, 3'b000);
        fetch(0);
        cyc("add_exec", ST_ER, 1'b1, 1'b0, 1'b0);
        cyc("add_wb", ST_AW, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        // lw with three wait states on the data read
        set_ir("lw", 7'b0000011, 3'b010, 1'b0, 3'b000);
        fetch(2);
        cyc("lw_adr", ST_MA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw_wait", ST_MR, 1'b0, 1'b0, 1'b0);
        cyc("lw_read", ST_MR, 1'b1, 1'b0, 1'b0);
        cyc("lw_wb", ST_MWB, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        // sw with two wait states
        set_ir("sw", 7'b0100011, 3'b010, 1'b0, 3'b001);
        fetch(0);
        cyc("sw_adr", ST_MA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("sw_wait", ST_MW, 1'b0, 1'b0, 1'b0);
        cyc("sw_write", ST_MW, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        // beq taken, then not taken
        set_ir("beq", 7'b1100011, 3'b000, 1'b0, 3'b010);
        fetch(0);
        cyc("beq_taken", ST_BR, 1'b1, 1'b1, 1'b0);
        exp_instret++;
        fetch(0);
        cyc("beq_not_taken", ST_BR, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        // jalr: FETCH, DECODE, JALR, JAL, ALUWB
        set_ir("jalr", 7'b1100111, 3'b000, 1'b0, 3'b000);
        fetch(0);
        cyc("jalr_tgt", ST_JR, 1'b1, 1'b0, 1'b0);
        cyc("jalr_link", ST_J, 1'b1, 1'b0, 1'b0);
        cyc("jalr_wb", ST_AW, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        set_ir("jal", 7'b1101111, 3'b000, 1'b0, 3'b011);
        fetch(0);
        cyc("jal_link", ST_J, 1'b1, 1'b0, 1'b0);
        cyc("jal_wb", ST_AW, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        set_ir("addi", 7'b0010011, 3'b000, 1'b0, 3'b000);
        fetch(0);
        cyc("addi_exec", ST_EI, 1'b1, 1'b0, 1'b0);
        cyc("addi_wb", ST_AW, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        set_ir("lui", 7'b0110111, 3'b000, 1'b0, 3'b100);
        fetch(0);
        cyc("lui_wb", ST_LUI, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        set_ir("auipc", 7'b0010111, 3'b000, 1'b0, 3'b100);
        fetch(0);
        cyc("auipc_wb", ST_AW, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        // mul never waits on the divider
        set_ir("mul", 7'b0110011, 3'b000, 1'b1, 3'b000);
        fetch(0);
        cyc("mul_exec", ST_ER, 1'b1, 1'b0, 1'b0);
        cyc("mul_wb", ST_AW, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        // div: result after ten divider cycles when the divider is built in
        set_ir("div", 7'b0110011, 3'b100, 1'b1, 3'b000);
        fetch(0);
        cyc("div_exec", ST_ER, 1'b1, 1'b0, 1'b0);
`ifdef MC_CTRL_MULDIV_EN
        div_done_i = 1'b0;
        cyc("div_start", ST_DV, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cyc("div_busy", ST_DV, 1'b1, 1'b0, 1'b0);
        div_done_i = 1'b1;
        cyc("div_done", ST_DV, 1'b1, 1'b0, 1'b0);
        div_done_i = 1'b0;
`else
        div_done_i = 1'b1;
`endif
        cyc("div_wb", ST_AW, 1'b1, 1'b0, 1'b0);
        div_done_i = 1'b0;
        exp_instret++;

        // Illegal opcode: trap absorbs, never requests memory
        set_ir("illegal", 7'h7F, 3'b000, 1'b0, 3'b000);
        fetch(0);
        for (int i = 0; i < 100; i++) cyc("trap", ST_TR, 1'b1, 1'b0, 1'b0);
        check("trap_instret", instret_o, exp_instret);

        // Asynchronous reset pulse away from any clock edge
        mem_ready_i = 1'b0;
        #1;
        reset_i = 1'b1;
        #1;
        check("async_illegal", {31'h0, illegal_instr_o}, 32'h0);
        check("async_instret", instret_o, 32'h0);
        check("async_mem_req", {31'h0, mem_req_o}, 32'h0);
        #4;
        reset_i = 1'b0;
        exp_instret = 0;
        @(posedge clk_i);
        #1;

        // Sequencer resumes normally after the pulse
        set_ir("lui2", 7'b0110111, 3'b000, 1'b0, 3'b100);
        fetch(1);
        cyc("lui2_wb", ST_LUI, 1'b1, 1'b0, 1'b0);
        exp_instret++;
        check("final_instret", instret_o, exp_instret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
